fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer_pkg.sv | 14 +
 rtl/fetch_buffer_storage.sv | 30 +++
 rtl/fetch_buffer.sv | 112 +++++++++++
 tb/tb_fetch_buffer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared constants for the fetch -> decode boundary: word width, the NOP
// encoding used to fill an empty decode slot, and the sequential PC step.
package fetch_buffer_pkg;

  localparam int          WORD_WIDTH   = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam int          PC_INCREMENT = 4;

  // Pointer width that stays legal for a single-entry buffer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_buffer_storage.sv
// Register array holding {PC, instruction} pairs: one synchronous write
// port and one asynchronous read port. Contents are never reset; validity
// is tracked by the occupancy counter in the parent.
module fetch_buffer_storage
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 2 * WORD_WIDTH,
  parameter int PW    = 1
) (
  input  logic          Clk,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [PW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write the incoming entry at the tail slot.
  always_ff @(posedge Clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_buffer.sv
// Decoupling FIFO between fetch and decode.
// Handshake: an entry moves across a boundary only in a cycle where both
// valid and ready are high at the rising edge (InValid/InReady on the push
// side, OutValid/OutReady on the pop side); Flush cancels both. Ready and
// valid are functions of registered occupancy only, so neither side sees a
// combinational path from the other. A pushed word is visible at the head
// one cycle later; there is no bypass.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       InValid,
  input  logic [WIDTH-1:0]           InInstruction,
  input  logic [WIDTH-1:0]           InPC,
  output logic                       InReady,
  output logic                       OutValid,
  output logic [WIDTH-1:0]           OutInstruction,
  output logic [WIDTH-1:0]           OutPC,
  output logic [WIDTH-1:0]           OutPCPlus4,
  input  logic                       OutReady,
  input  logic                       Flush,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = ptr_width(DEPTH);
  localparam int DW = 2 * WIDTH;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          push, pop;
  logic [DW-1:0] head_data;
  logic [WIDTH-1:0] head_instr, head_pc;

  assign InReady  = (count_q < CW'(DEPTH));
  assign OutValid = (count_q != '0);
  assign push     = InValid  && InReady  && !Flush;
  assign pop      = OutValid && OutReady && !Flush;

  // Next-state for pointers and occupancy; Flush empties the buffer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; Reset wins over everything else.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_buffer_storage #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .PW    (PW)
  ) u_storage (
    .Clk     (Clk),
    .we_i    (push && !Reset),
    .waddr_i (wr_ptr_q),
    .wdata_i ({InPC, InInstruction}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_data)
  );

  assign head_instr = head_data[WIDTH-1:0];
  assign head_pc    = head_data[DW-1:WIDTH];

  // Head outputs are masked to NOP/zero whenever nothing is held.
  always_comb begin
    OutInstruction = WIDTH'(NOP_INSTR);
    OutPC          = '0;
    OutPCPlus4     = '0;
    if (OutValid) begin
      OutInstruction = head_instr;
      OutPC          = head_pc;
      OutPCPlus4     = head_pc + WIDTH'(PC_INCREMENT);
    end
  end

  assign Count = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model.
module tb_fetch_buffer;

  localparam int DEPTH = 2;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_instr;
  logic [W-1:0] in_pc;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_instr;
  logic [W-1:0] out_pc;
  logic [W-1:0] out_pc4;
  logic         out_ready;
  logic         flush;
  logic [1:0]   count;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {pc, instr} in arrival order.
  logic [2*W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .Clk            (clk),
    .Reset          (rst),
    .InValid        (in_valid),
    .InInstruction  (in_instr),
    .InPC           (in_pc),
    .InReady        (in_ready),
    .OutValid       (out_valid),
    .OutInstruction (out_instr),
    .OutPC          (out_pc),
    .OutPCPlus4     (out_pc4),
    .OutReady       (out_ready),
    .Flush          (flush),
    .Count          (count)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output against the model's current contents.
  task automatic check_outputs();
    logic [W-1:0] e_instr, e_pc, e_pc4;
    int n;
    n = exp_q.size();
    e_instr = '0;
    e_pc    = '0;
    e_pc4   = '0;
    if (n != 0) begin
      e_instr = exp_q[0][W-1:0];
      e_pc    = exp_q[0][2*W-1:W];
      e_pc4   = e_pc + 32'd4;
    end
    check("count",     64'(count),     64'(n));
    check("in_ready",  64'(in_ready),  64'(n < DEPTH));
    check("out_valid", 64'(out_valid), 64'(n != 0));
    check("out_instr", 64'(out_instr), 64'(e_instr));
    check("out_pc",    64'(out_pc),    64'(e_pc));
    check("out_pc4",   64'(out_pc4),   64'(e_pc4));
  endtask

  // ---------------- driver ----------------
  // One clock: drive at negedge, check current state, then advance model
  // at the rising edge.
  task automatic cycle(input logic r, input logic v, input logic [W-1:0] instr,
                       input logic [W-1:0] pc, input logic ordy, input logic fl);
    bit do_push, do_pop;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    check_outputs();
    do_pop  = (exp_q.size() != 0) && ordy;
    do_push = v && (exp_q.size() < DEPTH);
    @(posedge clk);
    if (r || fl) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({pc, instr});
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, ordy, 1'b0);
  endtask

  task automatic push_w(input logic [W-1:0] instr, input logic [W-1:0] pc, input logic ordy);
    cycle(1'b0, 1'b1, instr, pc, ordy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b0; flush = 1'b0;

    // Reset for 3 cycles, then check the post-reset state.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    check("rst_count",     64'(count),     64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_instr", 64'(out_instr), 64'd0);

    // Single push while decode stalls; head visible next cycle, held.
    push_w(32'h2010_0005, 32'h0, 1'b0);
    #2;
    check("push1_valid", 64'(out_valid), 64'd1);
    check("push1_pc",    64'(out_pc),    64'h0);
    check("push1_pc4",   64'(out_pc4),   64'h4);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      #2;
      check("stall_instr", 64'(out_instr), 64'h2010_0005);
    end

    // Three pushes from empty with decode stalled: third is dropped.
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    push_w(32'hA1, 32'h100, 1'b0);
    push_w(32'hA2, 32'h104, 1'b0);
    #2;
    check("full_count",    64'(count),    64'd2);
    check("full_in_ready", 64'(in_ready), 64'd0);
    push_w(32'hA3, 32'h108, 1'b0);
    #2;
    check("full_head_pc",  64'(out_pc),   64'h100);
    idle(1'b1);
    idle(1'b1);
    #2;
    check("drop3_empty",   64'(out_valid), 64'd0);

    // Simultaneous push and pop at Count=1.
    push_w(32'hB4, 32'h4, 1'b0);
    push_w(32'hB8, 32'h8, 1'b1);
    #2;
    check("pp_count",   64'(count),  64'd1);
    check("pp_head_pc", 64'(out_pc), 64'h8);
    // Ten back-to-back words, pointers wrap repeatedly.
    for (int i = 0; i < 10; i++) push_w(32'hC000 + i, 32'h1000 + 4 * i, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Flush at Count=2 with a concurrent push.
    push_w(32'hD1, 32'h200, 1'b0);
    push_w(32'hD2, 32'h204, 1'b0);
    cycle(1'b0, 1'b1, 32'hD3, 32'h208, 1'b1, 1'b1);
    #2;
    check("flush_count", 64'(count),     64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    idle(1'b0);

    // PC+4 wraps modulo 2^32.
    push_w(32'hE0, 32'hFFFF_FFFC, 1'b0);
    #2;
    check("pc4_wrap", 64'(out_pc4), 64'h0);
    push_w(32'hE1, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'hE2, 32'h10, 1'b1, 1'b0);
    #2;
    check("midrst_count", 64'(count), 64'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
            $urandom, $urandom, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0));
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
